// File: rtl/mole_field_painter_if.sv
// Pixel-write bus between mole_field_painter and the VGA adapter.
// The painter drives x/y/color/plot and status; the game logic drives hole.
interface mole_field_painter_if;
    logic [7:0] hole;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] color;
    logic       plot;
    logic       busy;
    logic       frame_done;

    modport master (
        input  hole,
        output x, y, color, plot, busy, frame_done
    );

    modport slave (
        output hole,
        input  x, y, color, plot, busy, frame_done
    );
endinterface

// File: rtl/mole_field_painter.sv
// Pixel-write generator for the whac-a-mole 320x240 screen.
// Paints the full frame after reset, then repaints only the 30x30 hole
// boxes whose hole[] bit changed. One registered pixel write per clock.
module mole_field_painter #(
    parameter int         SCREEN_W   = 320,
    parameter int         SCREEN_H   = 240,
    parameter int         HOLE_SIZE  = 30,
    parameter int         HOLE_X0    = 25,
    parameter int         HOLE_DX    = 80,
    parameter int         HOLE_Y0    = 60,
    parameter int         HOLE_DY    = 90,
    parameter logic [2:0] BG_COLOR   = 3'b010,
    parameter logic [2:0] HOLE_COLOR = 3'b000,
    parameter logic [2:0] MOLE_COLOR = 3'b110
) (
    input  logic                    clk,
    input  logic                    rst,
    mole_field_painter_if.master    bus
);

    localparam logic [2:0] INIT  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] IDLE  = 3'd2;
    localparam logic [2:0] SCAN  = 3'd3;
    localparam logic [2:0] BOX   = 3'd4;

    localparam int BW = $clog2(HOLE_SIZE);

    logic [2:0]    state;
    logic [7:0]    snap;     // hole value currently shown on screen
    logic [7:0]    pend;     // boxes still awaiting repaint in this pass
    logic [2:0]    idx;
    logic [8:0]    cx;
    logic [7:0]    cy;
    logic [BW-1:0] bx;
    logic [BW-1:0] by;
    logic [8:0]    px;
    logic [8:0]    py;
    logic [2:0]    pix_color;

    function automatic logic [8:0] box_x0(input logic [2:0] i);
        return 9'(HOLE_X0 + int'(i[1:0]) * HOLE_DX);
    endfunction

    function automatic logic [8:0] box_y0(input logic [2:0] i);
        return 9'(HOLE_Y0 + int'(i[2]) * HOLE_DY);
    endfunction

    function automatic logic [2:0] color_at(input logic [8:0] qx, input logic [8:0] qy,
                                            input logic [7:0] s);
        logic [2:0] c;
        c = BG_COLOR;
        for (int unsigned i = 0; i < 8; i++) begin
            if (int'(qx) >= int'(box_x0(3'(i))) && int'(qx) < int'(box_x0(3'(i))) + HOLE_SIZE &&
                int'(qy) >= int'(box_y0(3'(i))) && int'(qy) < int'(box_y0(3'(i))) + HOLE_SIZE)
                c = s[i] ? MOLE_COLOR : HOLE_COLOR;
        end
        return c;
    endfunction

    // Pixel addressed this cycle: screen raster in CLEAR, box-relative in BOX
    always_comb begin
        px = cx;
        py = {1'b0, cy};
        if (state == BOX) begin
            px = box_x0(idx) + 9'(bx);
            py = box_y0(idx) + 9'(by);
        end
        pix_color = color_at(px, py, snap);
    end

    assign bus.busy = (state != IDLE);

    // Sequencer: full-frame paint, change detection, per-box repaint
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.x          <= '0;
            bus.y          <= '0;
            bus.color      <= '0;
            bus.plot       <= 1'b0;
            bus.frame_done <= 1'b0;
            snap           <= '0;
            pend           <= '0;
            state          <= INIT;
            idx            <= '0;
            cx             <= '0;
            cy             <= '0;
            bx             <= '0;
            by             <= '0;
        end else begin
            bus.plot       <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                INIT: begin
                    snap  <= bus.hole;
                    cx    <= '0;
                    cy    <= '0;
                    state <= CLEAR;
                end
                CLEAR: begin
                    bus.x     <= px;
                    bus.y     <= py[7:0];
                    bus.color <= pix_color;
                    bus.plot  <= 1'b1;
                    if (cx == 9'(SCREEN_W - 1)) begin
                        cx <= '0;
                        if (cy == 8'(SCREEN_H - 1)) begin
                            cy             <= '0;
                            bus.frame_done <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            cy <= cy + 8'd1;
                        end
                    end else begin
                        cx <= cx + 9'd1;
                    end
                end
                IDLE: begin
                    if (bus.hole != snap) begin
                        pend  <= bus.hole ^ snap;
                        snap  <= bus.hole;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (pend[idx]) begin
                        bx    <= '0;
                        by    <= '0;
                        state <= BOX;
                    end else if (idx == 3'd7) begin
                        bus.frame_done <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                BOX: begin
                    bus.x     <= px;
                    bus.y     <= py[7:0];
                    bus.color <= pix_color;
                    bus.plot  <= 1'b1;
                    if (bx == BW'(HOLE_SIZE - 1)) begin
                        bx <= '0;
                        if (by == BW'(HOLE_SIZE - 1)) begin
                            by        <= '0;
                            pend[idx] <= 1'b0;
                            if (idx == 3'd7) begin
                                bus.frame_done <= 1'b1;
                                state          <= IDLE;
                            end else begin
                                idx   <= idx + 3'd1;
                                state <= SCAN;
                            end
                        end else begin
                            by <= by + BW'(1);
                        end
                    end else begin
                        bx <= bx + BW'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_field_painter.sv
// Scoreboard bench for mole_field_painter: stimulus pushes expected pixel
// writes, a negedge monitor pops and compares every plot.
module tb_mole_field_painter;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mole_field_painter_if bus();

    mole_field_painter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    pix_t       exp_q[$];
    logic [2:0] scr [0:76799];
    int total = 0, bad = 0;
    int cyc = 0, plot_cnt = 0, fd_cnt = 0;
    int mark_a = 0, mark_b = 0, ca = 0, cb = 0, c_fd1 = 0;
    bit mon_on = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every plot must match the head of the scoreboard queue
    always @(negedge clk) begin
        if (mon_on && bus.plot) begin
            pix_t e;
            plot_cnt++;
            if (plot_cnt == mark_a) ca = cyc;
            if (plot_cnt == mark_b) cb = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%b, none expected",
                         bus.x, bus.y, bus.color);
            end else begin
                e = exp_q.pop_front();
                if ({bus.x, bus.y, bus.color} !== e) begin
                    bad++;
                    $display("FAIL plot_seq: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b",
                             bus.x, bus.y, bus.color, e.x, e.y, e.c);
                end
            end
            if (bus.x < 320 && bus.y < 240)
                scr[int'(bus.y) * 320 + int'(bus.x)] = bus.color;
        end
        if (mon_on && bus.frame_done) begin
            fd_cnt++;
            if (fd_cnt == 1) c_fd1 = cyc;
            check("busy_at_frame_done", int'(bus.busy), 0);
        end
    end

    function automatic logic [2:0] model_color(int px, int py, logic [7:0] s);
        logic [2:0] c = 3'b010;
        for (int i = 0; i < 8; i++) begin
            int x0 = 25 + 80 * (i % 4);
            int y0 = 60 + 90 * (i / 4);
            if (px >= x0 && px <= x0 + 29 && py >= y0 && py <= y0 + 29)
                c = s[i] ? 3'b110 : 3'b000;
        end
        return c;
    endfunction

    task automatic push_frame(logic [7:0] s, int rows);
        for (int py = 0; py < rows; py++)
            for (int px = 0; px < 320; px++)
                exp_q.push_back('{x: 9'(px), y: 8'(py), c: model_color(px, py, s)});
    endtask

    task automatic push_box(int i, bit mole);
        int x0 = 25 + 80 * (i % 4);
        int y0 = 60 + 90 * (i / 4);
        for (int by = 0; by < 30; by++)
            for (int bx = 0; bx < 30; bx++)
                exp_q.push_back('{x: 9'(x0 + bx), y: 8'(y0 + by), c: mole ? 3'b110 : 3'b000});
    endtask

    task automatic wait_fd(string name, int n, int budget);
        int k = 0;
        while ((fd_cnt < n || exp_q.size() != 0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_timeout"}, int'(k >= budget), 0);
        repeat (3) begin @(posedge clk); #1; end
        check({name, "_frame_done_count"}, fd_cnt, n);
        check({name, "_busy_idle"}, int'(bus.busy), 0);
    endtask

    task automatic wait_plots(int n, int budget);
        int k = 0;
        while (plot_cnt < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("mid_pass_wait_timeout", int'(k >= budget), 0);
    endtask

    task automatic spot(string name, int px, int py, logic [2:0] c);
        check(name, int'(scr[py * 320 + px]), int'(c));
    endtask

    initial begin
        int base_p, base_f, rcyc, k;
        bus.hole = 8'h00;
        rst = 1'b1;
        @(posedge clk); #1;
        rcyc = cyc;
        rst = 1'b0;
        @(negedge clk);
        check("reset_plot", int'(bus.plot), 0);
        check("reset_x", int'(bus.x), 0);
        check("reset_y", int'(bus.y), 0);
        check("reset_color", int'(bus.color), 0);
        check("reset_frame_done", int'(bus.frame_done), 0);
        check("reset_busy", int'(bus.busy), 1);

        // Full frame with hole=0 sampled in INIT; hole changes to 02 mid-CLEAR
        push_frame(8'h00, 240);
        push_box(1, 1'b1);
        mark_a = 1;
        mark_b = 76800;
        mon_on = 1'b1;
        repeat (1000) @(posedge clk);
        #1 bus.hole = 8'h02;
        wait_fd("full_frame", 2, 80000);
        check("full_frame_first_plot_cycle", ca, rcyc + 2);
        check("full_frame_consecutive", cb - ca, 76799);
        check("full_frame_done_on_last_plot", c_fd1, cb);
        check("full_frame_plots", plot_cnt, 76800 + 900);
        spot("px_0_0", 0, 0, 3'b010);
        spot("px_25_60", 25, 60, 3'b000);
        spot("px_54_89", 54, 89, 3'b000);
        spot("px_55_60", 55, 60, 3'b010);
        spot("px_105_60_box1", 105, 60, 3'b110);
        spot("px_134_89_box1", 134, 89, 3'b110);
        spot("px_104_60", 104, 60, 3'b010);
        spot("px_265_150_box7", 265, 150, 3'b000);

        // Single box repaint: box 0 becomes a mole
        base_p = plot_cnt; base_f = fd_cnt;
        push_box(0, 1'b1);
        bus.hole = 8'h03;
        wait_fd("box0_mole", base_f + 1, 2000);
        check("box0_mole_plots", plot_cnt - base_p, 900);
        spot("px_25_60_mole", 25, 60, 3'b110);
        spot("px_54_89_mole", 54, 89, 3'b110);

        // Clear both moles back to empty holes
        base_p = plot_cnt; base_f = fd_cnt;
        push_box(0, 1'b0);
        push_box(1, 1'b0);
        bus.hole = 8'h00;
        wait_fd("clear_01", base_f + 1, 3000);
        check("clear_01_plots", plot_cnt - base_p, 1800);

        // Two bits together: box 0 then box 7 in one pass
        base_p = plot_cnt; base_f = fd_cnt;
        push_box(0, 1'b1);
        push_box(7, 1'b1);
        bus.hole = 8'h81;
        wait_fd("pair_0_7", base_f + 1, 3000);
        check("pair_0_7_plots", plot_cnt - base_p, 1800);
        spot("px_265_150", 265, 150, 3'b110);
        spot("px_294_179", 294, 179, 3'b110);
        spot("px_295_179", 295, 179, 3'b010);

        // Bit 3 toggles mid-BOX of box 0: box 0 completes, second pass does box 3
        base_p = plot_cnt; base_f = fd_cnt;
        push_box(0, 1'b0);
        push_box(3, 1'b1);
        bus.hole = 8'h80;
        wait_plots(base_p + 100, 500);
        bus.hole = 8'h88;
        wait_fd("midbox_toggle", base_f + 2, 4000);
        check("midbox_toggle_plots", plot_cnt - base_p, 1800);
        spot("px_265_60_box3", 265, 60, 3'b110);
        spot("px_294_89_box3", 294, 89, 3'b110);
        spot("px_25_60_empty", 25, 60, 3'b000);

        // Reset mid-BOX: plot drops next cycle, CLEAR restarts from (0,0)
        push_box(3, 1'b0);
        bus.hole = 8'h00;
        wait_plots(plot_cnt + 200, 500);
        rst = 1'b1;
        bus.hole = 8'h10;
        @(posedge clk); #1;
        rcyc = cyc;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midbox_reset_plot", int'(bus.plot), 0);
        check("midbox_reset_x", int'(bus.x), 0);
        check("midbox_reset_busy", int'(bus.busy), 1);
        base_p = plot_cnt;
        push_frame(8'h10, 4);
        mark_a = base_p + 1;
        mark_b = base_p + 1280;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        mon_on = 1'b0;
        check("restart_timeout", int'(k >= 3000), 0);
        check("restart_first_plot_cycle", ca, rcyc + 2);
        check("restart_consecutive", cb - ca, 1279);
        check("restart_plots", plot_cnt - base_p, 1280);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
